// File: rtl/uart_rx_checker_if.sv
// Read-side handshake between the UART core's RX FIFO and its consumer.
// The checker drives the pop strobe (master); the uart core supplies head data and empty status.
interface uart_rx_checker_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;

  modport master (
    input  rx_empty,
    input  r_data,
    output rd_uart
  );

  modport slave (
    output rx_empty,
    output r_data,
    input  rd_uart
  );
endinterface

// File: rtl/uart_rx_checker.sv
// Pops bytes from the UART RX FIFO, compares them with the constant test byte,
// tracks link lock, counts bytes and errors, and flags silence on the link.
module uart_rx_checker #(
  parameter int         clk_freq   = 50000000,
  parameter logic [7:0] EXPECTED   = 8'h55,
  parameter int         LOCK_COUNT = 4,
  parameter int         TIMEOUT_MS = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  uart_rx_checker_if.master   bus,
  output logic                locked,
  output logic                mismatch,
  output logic                timeout,
  output logic                err_seen,
  output logic [7:0]          last_byte,
  output logic [15:0]         byte_count,
  output logic [15:0]         err_count
);

  localparam int TIMEOUT_CYC = clk_freq / 1000 * TIMEOUT_MS;
  localparam int TIMER_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CNT_W       = $clog2(LOCK_COUNT + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(LOCK_COUNT - 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rd_uart_q, rd_uart_d;
  logic                 eval_q, eval_d;
  logic [7:0]           last_byte_q, last_byte_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 timeout_q, timeout_d;
  logic                 mismatch_q, mismatch_d;
  logic                 err_seen_q, err_seen_d;
  logic [15:0]          byte_count_q, byte_count_d;
  logic [15:0]          err_count_q, err_count_d;

  logic capture;
  logic is_match;
  logic expire;
  logic locked_miss;

  // A capture is blocked during the pop cycle, which limits reads to one per two cycles.
  assign capture     = !bus.rx_empty && !rd_uart_q;
  assign is_match    = (last_byte_q == EXPECTED);
  assign expire      = timeout_d && !timeout_q;
  assign locked_miss = eval_q && !is_match && (state_q == ST_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SEARCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts consecutive matches in SEARCH and consecutive misses in LOCKED.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (eval_q) begin
      case (state_q)
        ST_SEARCH: begin
          if (!is_match) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (is_match) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_SEARCH;
          cnt_d   = '0;
        end
      endcase
    end
    if (expire) begin
      state_d = ST_SEARCH;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bus.rd_uart = rd_uart_q;
    locked      = (state_q == ST_LOCKED);
    mismatch    = mismatch_q;
    timeout     = timeout_q;
    err_seen    = err_seen_q;
    last_byte   = last_byte_q;
    byte_count  = byte_count_q;
    err_count   = err_count_q;
  end

  always_comb begin
    rd_uart_d   = capture;
    eval_d      = capture;
    last_byte_d = capture ? bus.r_data : last_byte_q;
    mismatch_d  = eval_q && !is_match;

    // A capture on the expiry edge wins, so timeout never rises on that edge.
    if (capture) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
    timeout_d = !capture && (timer_d == TIMER_LAST);

    byte_count_d = eval_q ? byte_count_q + 16'd1 : byte_count_q;

    err_count_d = err_count_q;
    if (locked_miss && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end

    err_seen_d = err_seen_q || locked_miss || expire;

    if (clr) begin
      byte_count_d = '0;
      err_count_d  = '0;
      err_seen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_uart_q    <= 1'b0;
      eval_q       <= 1'b0;
      last_byte_q  <= '0;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      mismatch_q   <= 1'b0;
      err_seen_q   <= 1'b0;
      byte_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      rd_uart_q    <= rd_uart_d;
      eval_q       <= eval_d;
      last_byte_q  <= last_byte_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      mismatch_q   <= mismatch_d;
      err_seen_q   <= err_seen_d;
      byte_count_q <= byte_count_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule
